// File: rtl/wb_stage_pkg.sv
// Shared definitions for the write-back stage: RISC-V word/register-file
// geometry, load-size encodings and FSM state encodings.
package wb_stage_pkg;

    localparam int unsigned RISCV_WORD_WIDTH = 32;
    localparam int unsigned GP_REG_COUNT     = 32;

    // Load-size encodings as carried on ex_load_size_i (2'b11 also means word)
    localparam logic [1:0] LOAD_SIZE_BYTE = 2'b00;
    localparam logic [1:0] LOAD_SIZE_HALF = 2'b01;
    localparam logic [1:0] LOAD_SIZE_WORD = 2'b10;

    // FSM states
    localparam logic [0:0] ST_IDLE      = 1'b0;
    localparam logic [0:0] ST_WAIT_LOAD = 1'b1;

endpackage

// File: rtl/wb_stage_load_align.sv
// load_align: combinational extraction of a byte/half/word from an aligned
// memory word, followed by zero- or sign-extension.
//   rdata_i     aligned word from data memory
//   size_i      load size encoding
//   unsigned_i  1 = zero-extend, 0 = sign-extend
//   lsb_i       load address bits [1:0]
//   word_o      register-file ready value
module load_align
    import wb_stage_pkg::*;
#(
    parameter int unsigned WORD_W = RISCV_WORD_WIDTH
) (
    input  logic [WORD_W-1:0] rdata_i,
    input  logic [1:0]        size_i,
    input  logic              unsigned_i,
    input  logic [1:0]        lsb_i,
    output logic [WORD_W-1:0] word_o
);

    logic [WORD_W-1:0] byte_shifted;
    logic [WORD_W-1:0] half_shifted;
    logic [7:0]        byte_v;
    logic [15:0]       half_v;
    logic              byte_sign;
    logic              half_sign;

    // Shift the addressed lane down to bit 0; half ignores lsb[0]
    assign byte_shifted = rdata_i >> {lsb_i, 3'b000};
    assign half_shifted = rdata_i >> {lsb_i[1], 4'b0000};
    assign byte_v       = byte_shifted[7:0];
    assign half_v       = half_shifted[15:0];
    assign byte_sign    = ~unsigned_i & byte_v[7];
    assign half_sign    = ~unsigned_i & half_v[15];

    always_comb begin
        word_o = rdata_i;
        case (size_i)
            LOAD_SIZE_BYTE: word_o = {{(WORD_W-8){byte_sign}}, byte_v};
            LOAD_SIZE_HALF: word_o = {{(WORD_W-16){half_sign}}, half_v};
            default:        word_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// wb_stage: write-back stage. Accepts one execute result per cycle; ALU
// results are written the following cycle, loads wait (no timeout) for the
// data-memory response, then write the aligned/extended value.
//   ex_*         offer from execute (valid/ready handshake)
//   dmem_*       single-cycle load response
//   rf_write_*   register-file write port (registered, single-cycle strobe)
//   load_busy_o / load_rd_o  outstanding-load info for hazard stalling
//   err_o        sticky: load response arrived with nothing outstanding
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int unsigned WORD_W = RISCV_WORD_WIDTH,
    parameter int unsigned REG_AW = $clog2(GP_REG_COUNT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid_i,
    output logic              ex_ready_o,
    input  logic [REG_AW-1:0] ex_rd_i,
    input  logic [WORD_W-1:0] ex_result_i,
    input  logic              ex_is_load_i,
    input  logic [1:0]        ex_load_size_i,
    input  logic              ex_load_unsigned_i,
    input  logic [1:0]        ex_addr_lsb_i,
    input  logic              dmem_rvalid_i,
    input  logic [WORD_W-1:0] dmem_rdata_i,
    output logic              rf_write_en_o,
    output logic [REG_AW-1:0] rf_write_addr_o,
    output logic [WORD_W-1:0] rf_write_data_o,
    output logic              load_busy_o,
    output logic [REG_AW-1:0] load_rd_o,
    output logic              err_o
);

    logic [0:0]        state_q,   state_d;
    logic [REG_AW-1:0] ld_rd_q,   ld_rd_d;
    logic [1:0]        ld_size_q, ld_size_d;
    logic              ld_uns_q,  ld_uns_d;
    logic [1:0]        ld_lsb_q,  ld_lsb_d;
    logic              wr_en_q,   wr_en_d;
    logic [REG_AW-1:0] wr_addr_q, wr_addr_d;
    logic [WORD_W-1:0] wr_data_q, wr_data_d;
    logic              err_q,     err_d;
    logic [WORD_W-1:0] aligned_word;
    logic              accept;

    load_align #(.WORD_W(WORD_W)) u_load_align (
        .rdata_i    (dmem_rdata_i),
        .size_i     (ld_size_q),
        .unsigned_i (ld_uns_q),
        .lsb_i      (ld_lsb_q),
        .word_o     (aligned_word)
    );

    assign ex_ready_o  = (state_q == ST_IDLE);
    assign accept      = ex_valid_i && ex_ready_o;
    assign load_busy_o = (state_q == ST_WAIT_LOAD);
    assign load_rd_o   = ld_rd_q;
    assign rf_write_en_o   = wr_en_q;
    assign rf_write_addr_o = wr_addr_q;
    assign rf_write_data_o = wr_data_q;
    assign err_o           = err_q;

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ld_rd_q   <= '0;
            ld_size_q <= '0;
            ld_uns_q  <= 1'b0;
            ld_lsb_q  <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ld_rd_q   <= ld_rd_d;
            ld_size_q <= ld_size_d;
            ld_uns_q  <= ld_uns_d;
            ld_lsb_q  <= ld_lsb_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            err_q     <= err_d;
        end
    end

    // Next-state and write-port logic; rd=0 completes without a strobe and
    // leaves addr/data untouched
    always_comb begin
        state_d   = state_q;
        ld_rd_d   = ld_rd_q;
        ld_size_d = ld_size_q;
        ld_uns_d  = ld_uns_q;
        ld_lsb_d  = ld_lsb_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        err_d     = err_q;

        case (state_q)
            ST_IDLE: begin
                if (dmem_rvalid_i) begin
                    err_d = 1'b1;
                end
                if (accept) begin
                    if (ex_is_load_i) begin
                        state_d   = ST_WAIT_LOAD;
                        ld_rd_d   = ex_rd_i;
                        ld_size_d = ex_load_size_i;
                        ld_uns_d  = ex_load_unsigned_i;
                        ld_lsb_d  = ex_addr_lsb_i;
                    end else if (ex_rd_i != '0) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = ex_rd_i;
                        wr_data_d = ex_result_i;
                    end
                end
            end
            ST_WAIT_LOAD: begin
                if (dmem_rvalid_i) begin
                    state_d = ST_IDLE;
                    if (ld_rd_q != '0) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = ld_rd_q;
                        wr_data_d = aligned_word;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have parameter WORD_W, default `RISCV_WORD_WIDTH (32), meaning datapath width.
REQ-002 SHALL have parameter REG_AW, default $clog2(`GP_REG_COUNT) (5), meaning register address width.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous and active-high.
REQ-005 ex_valid_i  in  1  execute result offered.
REQ-006 ex_ready_o  out  1  wb_stage accepts offer.
REQ-007 ex_rd_i  in  REG_AW  destination register.
REQ-008 ex_result_i  in  WORD_W  ALU result; ignored for loads.
REQ-009 ex_is_load_i  in  1  result comes from data memory.
REQ-010 ex_load_size_i  in  2  00 byte, 01 half, 10/11 word.
REQ-011 ex_load_unsigned_i  in  1  zero-extend, else sign-extend.
REQ-012 ex_addr_lsb_i  in  2  load address bits [1:0].
REQ-013 dmem_rvalid_i  in  1  load data valid, one-cycle pulse.
REQ-014 dmem_rdata_i  in  WORD_W  aligned word read from memory.
REQ-015 rf_write_en_o  out  1  register-file write strobe.
REQ-016 rf_write_addr_o  out  REG_AW  register-file write address.
REQ-017 rf_write_data_o  out  WORD_W  register-file write data.
REQ-018 load_busy_o  out  1  load outstanding (for hazard stall).
REQ-019 load_rd_o  out  REG_AW  destination of outstanding load.
REQ-020 err_o  out  1  sticky: dmem_rvalid_i seen with no load outstanding.

Function
REQ-021 SHALL implement FSM states IDLE and WAIT_LOAD; ex_ready_o = (state == IDLE).
REQ-022 Accept = ex_valid_i && ex_ready_o; SHALL be the only event capturing ex_* inputs.
REQ-023 Non-load accept SHALL register a write: the cycle after accept, rf_write_en_o=1, addr=ex_rd_i, data=ex_result_i; state stays IDLE (back-to-back, one write per cycle).
REQ-024 Load accept SHALL capture rd, size, unsigned, lsb; go to WAIT_LOAD; load_busy_o=1, load_rd_o=captured rd, from the next cycle until the write cycle.
REQ-025 In WAIT_LOAD with dmem_rvalid_i=1: the next cycle SHALL write aligned data to captured rd and return to IDLE; ex_ready_o is 1 in that write cycle.
REQ-026 WAIT_LOAD SHALL have no timeout; waits indefinitely for dmem_rvalid_i.
REQ-027 Alignment: byte = rdata[8*lsb+7 : 8*lsb]; half = rdata[16*lsb[1]+15 : 16*lsb[1]], lsb[0] ignored; word = rdata, lsbs ignored.
REQ-028 Extension to WORD_W SHALL follow ex_load_unsigned_i: zero-extend if 1, else replicate the MSB; ignored for word loads.
REQ-029 Writes to rd=0 SHALL complete the transaction normally but hold rf_write_en_o=0.
REQ-030 rf_write_en_o SHALL be a single-cycle pulse per transaction; addr/data hold last value when en=0.
REQ-031 dmem_rvalid_i in IDLE SHALL be ignored for writes and set err_o=1 until reset.
REQ-032 ex_valid_i while ex_ready_o=0 SHALL be ignored; the upstream stage holds its offer.

Reset
REQ-033 On rst, state SHALL be IDLE; rf_write_en_o=0, rf_write_addr_o=0, rf_write_data_o=0, load_busy_o=0, load_rd_o=0, err_o=0; ex_ready_o=1 after release.
REQ-034 Reset during WAIT_LOAD SHALL discard the outstanding load; a later dmem_rvalid_i sets err_o.

Structure
REQ-035 WORD width, GP_REG_COUNT and load-size encodings SHALL live in riscv_defines.v; no local literals for them.
REQ-036 Alignment/extension SHALL be a combinational sub-module load_align (rdata, size, unsigned, lsb -> word).
REQ-037 Outputs rf_write_* connect directly to the register-file write port; no further registering.

Verification
REQ-038 ALU accepts rd=5 0xDEADBEEF, then rd=6 0x1, back-to-back -> en pulses on the two following cycles, x5=0xDEADBEEF, x6=0x1.
REQ-039 Load byte signed, lsb=2, rdata=0x12_80_34_56 -> write 0xFFFFFF80; same load unsigned -> 0x00000080.
REQ-040 Load half signed, lsb=3, rdata=0x8001_7FFF -> write 0xFFFF8001; ex_ready_o=0 and load_busy_o=1 throughout the 5-cycle wait.
REQ-041 ALU accept with rd=0, result 0x55 -> rf_write_en_o stays 0; next accept proceeds normally.
REQ-042 dmem_rvalid_i pulse in IDLE -> no write, err_o=1 held until rst.
REQ-043 rst asserted mid-WAIT_LOAD -> all outputs 0 asynchronously; IDLE after release; the late rvalid sets err_o, no write.
